// File: rtl/spi_cfg_pkg.sv
// Shared frame layout, FSM state encoding and helpers for the SPI configuration target.
package spi_cfg_pkg;

  localparam int FRAME_W     = 24;
  localparam int RW_BIT      = 23;
  localparam int ADDR_MSB    = 22;
  localparam int ADDR_LSB    = 8;
  localparam int DATA_W      = 8;
  localparam int HDR_W       = FRAME_W - DATA_W;
  localparam int FRM_ADDR_W  = ADDR_MSB - ADDR_LSB + 1;
  localparam int CNT_W       = 5;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    FULL,
    OVER,
    COMMIT
  } state_t;

  // True when a 15-bit frame address falls inside a 2**aw entry register file.
  function automatic logic addr_ok(input logic [FRM_ADDR_W-1:0] addr, input int aw);
    return (addr >> aw) == '0;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin with single-cycle rise/fall pulses.
module spi_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic meta, sync, prev;

  // Resetting to 0 means a pin held low through reset never produces a fall pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/spi_cfg_target.sv
// SPI mode-0 target for 24-bit {R/nW, ADDR[14:0], DATA[7:0]} configuration frames.
// Define SPI_CFG_RDBACK_EN to shift register contents out on miso for read frames.
module spi_cfg_target
  import spi_cfg_pkg::*;
#(
  parameter int         ADDR_W  = 4,
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic              wr_stb,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              frame_err,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  localparam int DEPTH = 2**ADDR_W;

  logic               sck_rise, sck_fall, cs_rise, cs_fall;
  logic               mosi_meta, mosi_s;
  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [FRAME_W-1:0] shreg, shreg_nxt;
  logic [DATA_W-1:0]  regs [DEPTH];
  logic               frame_ok, frame_wr;

  spi_sync_edge u_sck (.clk(clk), .rst(rst), .din(sck), .rise(sck_rise), .fall(sck_fall));
  spi_sync_edge u_cs  (.clk(clk), .rst(rst), .din(cs),  .rise(cs_rise),  .fall(cs_fall));

  // mosi shares the sck synchroniser depth so both arrive aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mosi_meta <= 1'b0;
      mosi_s    <= 1'b0;
    end else begin
      mosi_meta <= mosi;
      mosi_s    <= mosi_meta;
    end
  end

  assign shreg_nxt = {shreg[FRAME_W-2:0], mosi_s};
  assign frame_ok  = (count == CNT_W'(FRAME_W));
  assign frame_wr  = frame_ok && !shreg[RW_BIT] && addr_ok(shreg[ADDR_MSB:ADDR_LSB], ADDR_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      shreg     <= '0;
      wr_stb    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      frame_err <= 1'b0;
    end else begin
      wr_stb    <= 1'b0;
      frame_err <= 1'b0;
      if (cs_rise && state != IDLE && state != COMMIT) begin
        state <= COMMIT;
        if (frame_wr) begin
          wr_stb  <= 1'b1;
          wr_addr <= shreg[ADDR_LSB +: ADDR_W];
          wr_data <= shreg[DATA_W-1:0];
        end else if (!frame_ok) begin
          frame_err <= 1'b1;
        end
      end else begin
        case (state)
          IDLE, COMMIT: begin
            if (cs_fall) begin
              state <= ADDR;
              count <= '0;
            end else begin
              state <= IDLE;
            end
          end
          ADDR: if (sck_rise) begin
            shreg <= shreg_nxt;
            count <= count + 1'b1;
            if (count == CNT_W'(HDR_W - 1)) state <= DATA;
          end
          DATA: if (sck_rise) begin
            shreg <= shreg_nxt;
            count <= count + 1'b1;
            if (count == CNT_W'(FRAME_W - 1)) state <= FULL;
          end
          FULL: if (sck_rise) begin
            count <= count + 1'b1;
            state <= OVER;
          end
          default: ;
        endcase
      end
    end
  end

  // The array is written in the COMMIT cycle, one clock after the strobe is raised.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= RST_VAL;
    end else if (state == COMMIT && wr_stb) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rd_data = regs[rd_addr];

`ifdef SPI_CFG_RDBACK_EN
  logic [DATA_W-1:0] shreg_out, rb_lookup;
  logic              rd_act;

  assign rb_lookup = addr_ok(shreg_nxt[FRM_ADDR_W-1:0], ADDR_W) ?
                     regs[shreg_nxt[ADDR_W-1:0]] : '0;

  // The first sck fall of the data phase only enables the driver; later falls shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_out <= '0;
      rd_act    <= 1'b0;
      miso_oe   <= 1'b0;
    end else if (cs_rise || state == IDLE || state == COMMIT) begin
      shreg_out <= '0;
      rd_act    <= 1'b0;
      miso_oe   <= 1'b0;
    end else if (state == ADDR && sck_rise && count == CNT_W'(HDR_W - 1)) begin
      if (shreg_nxt[HDR_W-1]) begin
        rd_act    <= 1'b1;
        shreg_out <= rb_lookup;
      end
    end else if (rd_act && sck_fall) begin
      if (count == CNT_W'(HDR_W)) miso_oe <= 1'b1;
      else shreg_out <= {shreg_out[DATA_W-2:0], 1'b0};
    end
  end

  assign miso = shreg_out[DATA_W-1];
`else
  logic unused_sck_fall;
  assign unused_sck_fall = sck_fall;
  assign miso    = 1'b0;
  assign miso_oe = 1'b0;
`endif

endmodule
